gbuff_drain: RTL and testbench

//   Unloads a result region of a global buffer SRAM (1-cycle registered read) onto a valid/ready stream.

---
 rtl/gbuff_drain_pkg.sv | 30 +++
 rtl/gbuff_drain_fifo.sv | 79 +++++++
 rtl/gbuff_drain.sv | 199 +++++++++++++++++++
 tb/tb_gbuff_drain.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/gbuff_drain_pkg.sv
// ---------------------------------------------------------------------------
// gbuff_drain_pkg
//   Shared definitions for the global-buffer drain block:
//     - default data/address/length widths and FIFO depth
//     - FSM state encoding (IDLE / RUN / FLUSH / DONE)
//     - helper to size FIFO pointers
//   Optional feature macro used by the top: GBUFF_DRAIN_STRIDE_EN
// ---------------------------------------------------------------------------
package gbuff_drain_pkg;

    localparam int DW_DEF         = 32;   // data word width
    localparam int AW_DEF         = 10;   // SRAM word-address width
    localparam int LW_DEF         = 11;   // length counter width (len up to 2**AW)
    localparam int FIFO_DEPTH_DEF = 4;    // return-data buffer entries

    // Pointer width for a power-of-two FIFO; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int FIFO_PTR_W = ptr_width(FIFO_DEPTH_DEF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage : gbuff_drain_pkg

// File: rtl/gbuff_drain_fifo.sv
// ---------------------------------------------------------------------------
// gbuff_drain_fifo
//   DEPTH x DW synchronous FIFO with occupancy count. Read data is the head
//   entry presented combinationally (first-word fall-through). A push and a
//   pop in the same cycle are accepted even when full (the freed slot takes
//   the new word) and leave the count unchanged.
// Ports
//   clk          in   clock
//   rst          in   synchronous active-high reset (empties the FIFO)
//   i_push       in   write i_push_data this cycle
//   i_push_data  in   DW   data to write
//   i_pop        in   remove head entry this cycle
//   o_pop_data   out  DW   head entry (valid when !o_empty)
//   o_count      out  CW   number of stored entries
//   o_full       out  FIFO holds DEPTH entries
//   o_empty      out  FIFO holds no entries
// ---------------------------------------------------------------------------
module gbuff_drain_fifo
    import gbuff_drain_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF,
    localparam int PW   = ptr_width(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_push_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_pop_data,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of the others, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; emptiness is tracked by the
    // pointers/count, so stale contents are never observable and the array
    // can map onto plain RAM or flops without a reset tree.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_pop_data = r_mem[r_rd_ptr];
    assign o_count    = r_count;

endmodule : gbuff_drain_fifo

// File: rtl/gbuff_drain.sv
// ---------------------------------------------------------------------------
// gbuff_drain
//   Unloads a region of the output global buffer (1-cycle registered-read
//   SRAM) onto a valid/ready stream. A start pulse in IDLE captures base/len;
//   reads are issued while credit remains in the return FIFO, returned words
//   are buffered and streamed out with last on the final word, and done
//   pulses for one cycle after that word is accepted.
//
// Configuration
//   GBUFF_DRAIN_STRIDE_EN  defined: adds i_stride (captured with start),
//                          address step = stride. Undefined: step = 1.
//
// Ports
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   i_start      in   command strobe, sampled only in IDLE
//   i_base       in   AW   first word address
//   i_len        in   LW   number of words to drain
//   i_stride     in   AW   address step (only with GBUFF_DRAIN_STRIDE_EN)
//   o_sram_wen   out  SRAM write enable, always 0
//   o_sram_addr  out  AW   SRAM word address
//   o_sram_rd    out  read issued this cycle
//   i_sram_do    in   DW   SRAM read data (valid the cycle after o_sram_rd)
//   o_out_valid  out  stream word valid
//   i_out_ready  in   sink ready
//   o_out_data   out  DW   stream word (0 when not valid)
//   o_out_last   out  final word of the command
//   o_busy       out  command in progress (RUN/FLUSH)
//   o_done       out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module gbuff_drain
    import gbuff_drain_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int AW         = AW_DEF,
    parameter int LW         = LW_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic [AW-1:0] i_base,
    input  logic [LW-1:0] i_len,
`ifdef GBUFF_DRAIN_STRIDE_EN
    input  logic [AW-1:0] i_stride,
`endif
    output logic          o_sram_wen,
    output logic [AW-1:0] o_sram_addr,
    output logic          o_sram_rd,
    input  logic [DW-1:0] i_sram_do,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [DW-1:0] o_out_data,
    output logic          o_out_last,
    output logic          o_busy,
    output logic          o_done
);

    localparam int CW = ptr_width(FIFO_DEPTH) + 1;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [LW-1:0] r_len;
    logic [LW-1:0] r_issued;
    logic [LW-1:0] r_accepted;
    logic [AW-1:0] r_addr;
    logic          r_inflight;    // a read was issued last cycle; its data is on i_sram_do now
    logic [AW-1:0] w_step;

    logic [DW-1:0] w_fifo_data;
    logic [CW-1:0] w_fifo_count;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic          w_pop;
    logic          w_credit_ok;
    logic          w_accept_cmd;

`ifdef GBUFF_DRAIN_STRIDE_EN
    logic [AW-1:0] r_stride;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stride <= '0;
        end else if (w_accept_cmd) begin
            r_stride <= i_stride;
        end
    end

    assign w_step = r_stride;
`else
    assign w_step = AW'(1);
`endif

    assign w_accept_cmd = (r_state == ST_IDLE) && i_start;

    // Credit: every issued read must find a FIFO slot when its data returns,
    // so stored words plus the one in flight must stay below the depth.
    assign w_credit_ok = ({1'b0, w_fifo_count} + (CW+1)'(r_inflight)) < (CW+1)'(FIFO_DEPTH);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // ---------------- FSM: next-state logic ----------------
    // NOTE: combinational blocks assign a default to every output first, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) w_state_nxt = (i_len == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (r_issued == r_len) w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (w_pop && o_out_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_sram_rd = 1'b0;
        o_busy    = 1'b0;
        o_done    = 1'b0;
        case (r_state)
            ST_RUN: begin
                o_busy    = 1'b1;
                o_sram_rd = (r_issued != r_len) && w_credit_ok;
            end
            ST_FLUSH: o_busy = 1'b1;
            ST_DONE:  o_done = 1'b1;
            default: ;
        endcase
    end

    // ---------------- address generator / counters ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len      <= '0;
            r_issued   <= '0;
            r_accepted <= '0;
            r_addr     <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= o_sram_rd;
            if (w_accept_cmd) begin
                r_len      <= i_len;
                r_addr     <= i_base;
                r_issued   <= '0;
                r_accepted <= '0;
            end else begin
                if (o_sram_rd) begin
                    r_addr   <= r_addr + w_step;   // wraps modulo 2**AW
                    r_issued <= r_issued + LW'(1);
                end
                if (w_pop) r_accepted <= r_accepted + LW'(1);
            end
        end
    end

    // ---------------- return-data FIFO ----------------
    gbuff_drain_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_inflight),
        .i_push_data (i_sram_do),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_data),
        .o_count     (w_fifo_count),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // The credit rule guarantees the returning word never meets a full FIFO.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        r_inflight |-> (!w_fifo_full || w_pop));

    // ---------------- stream side ----------------
    assign o_out_valid = !w_fifo_empty;
    assign w_pop       = o_out_valid && i_out_ready;
    assign o_out_data  = o_out_valid ? w_fifo_data : '0;
    assign o_out_last  = o_out_valid && (r_accepted == (r_len - LW'(1)));

    assign o_sram_wen  = 1'b0;
    assign o_sram_addr = r_addr;

endmodule : gbuff_drain

// File: tb/tb_gbuff_drain.sv
// ---------------------------------------------------------------------------
// tb_gbuff_drain
//   Directed bench for gbuff_drain with a 1-cycle registered-read SRAM model
//   holding SRAM[i] = i + 100. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_gbuff_drain;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int LW = 11;

`ifdef GBUFF_DRAIN_STRIDE_EN
    localparam logic [AW-1:0] T6_STEP = 10'd16;
`else
    localparam logic [AW-1:0] T6_STEP = 10'd1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [AW-1:0] i_base;
    logic [LW-1:0] i_len;
    logic [AW-1:0] i_stride;
    logic          sram_wen;
    logic [AW-1:0] sram_addr;
    logic          sram_rd;
    logic [DW-1:0] sram_do;
    logic          out_valid;
    logic          i_out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [1024];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gbuff_drain dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_base      (i_base),
        .i_len       (i_len),
`ifdef GBUFF_DRAIN_STRIDE_EN
        .i_stride    (i_stride),
`endif
        .o_sram_wen  (sram_wen),
        .o_sram_addr (sram_addr),
        .o_sram_rd   (sram_rd),
        .i_sram_do   (sram_do),
        .o_out_valid (out_valid),
        .i_out_ready (i_out_ready),
        .o_out_data  (out_data),
        .o_out_last  (out_last),
        .o_busy      (busy),
        .o_done      (done)
    );

    // Registered-read SRAM: data for a read in cycle t is on sram_do in t+1.
    always @(posedge clk) begin
        if (sram_rd) sram_do <= mem[sram_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_wen"},   64'(sram_wen),  64'd0);
        check({tag, "_addr"},  64'(sram_addr), 64'd0);
        check({tag, "_rd"},    64'(sram_rd),   64'd0);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_data"},  64'(out_data),  64'd0);
        check({tag, "_last"},  64'(out_last),  64'd0);
        check({tag, "_busy"},  64'(busy),      64'd0);
        check({tag, "_done"},  64'(done),      64'd0);
    endtask

    // Issue one command and follow it to completion (or to an abort reset).
    // Called at a falling edge; returns at a falling edge.
    task automatic drain(input string tag, input logic [AW-1:0] base, input logic [AW-1:0] step,
                         input int len, input int stall_pct, input bit inject,
                         input int abort_after, input bit chk_timing);
        int            n_iss = 0;
        int            n_acc = 0;
        int            n_done = 0;
        int            post = 0;
        int            first_rd = -1;
        int            first_vld = -1;
        bit            held = 1'b0;
        logic [DW-1:0] held_data = '0;
        logic          held_last = 1'b0;
        logic [AW-1:0] exp_addr;
        logic [AW-1:0] a;

        exp_addr = base;
        i_start  = 1'b1;
        i_base   = base;
        i_len    = LW'(len);
        i_stride = step;
        @(negedge clk);
        i_start  = 1'b0;
        // Changing the command inputs after capture must have no effect.
        i_base   = ~base;
        i_len    = '1;
        i_stride = 10'd7;

        for (int cyc = 1; cyc < 400; cyc++) begin
            i_start = (inject && cyc == 2);   // second start while RUN
            i_out_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);

            if (cyc == 1) check({tag, "_busy_c1"}, 64'(busy), 64'd1);

            if (sram_rd) begin
                if (first_rd < 0) first_rd = cyc;
                check({tag, "_rd_addr"}, 64'(sram_addr), 64'(exp_addr));
                check({tag, "_rd_within_len"}, 64'(n_iss < len), 64'd1);
                exp_addr = exp_addr + step;
                n_iss++;
            end

            if (held) begin
                check({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
                check({tag, "_stall_data"},  64'(out_data),  64'(held_data));
                check({tag, "_stall_last"},  64'(out_last),  64'(held_last));
            end

            if (out_valid) begin
                if (first_vld < 0) first_vld = cyc;
                if (i_out_ready) begin
                    a = base + AW'(n_acc * int'(step));
                    check({tag, "_data"}, 64'(out_data), 64'(DW'(a) + 32'd100));
                    check({tag, "_last"}, 64'(out_last), 64'(n_acc == len - 1));
                    n_acc++;
                    held = 1'b0;
                end else begin
                    held      = 1'b1;
                    held_data = out_data;
                    held_last = out_last;
                end
            end

            if (done) n_done++;
            if (n_done > 0) post++;

            if (abort_after > 0 && n_acc == abort_after) begin
                rst = 1'b1;
                @(negedge clk);
                check_quiet({tag, "_abort"});
                rst = 1'b0;
                i_out_ready = 1'b1;
                return;
            end

            if (post == 3) break;
            @(negedge clk);
        end

        i_start     = 1'b0;
        i_out_ready = 1'b1;
        check({tag, "_issued"},   64'(n_iss),  64'(len));
        check({tag, "_accepted"}, 64'(n_acc),  64'(len));
        check({tag, "_done_cnt"}, 64'(n_done), 64'd1);
        if (chk_timing) begin
            check({tag, "_first_rd_cyc"},    64'(first_rd),  64'd1);
            check({tag, "_first_valid_cyc"}, 64'(first_vld), 64'd3);
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i) + 32'd100;
        sram_do     = '0;
        rst         = 1'b1;
        i_start     = 1'b0;
        i_base      = '0;
        i_len       = '0;
        i_stride    = '0;
        i_out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;
        @(negedge clk);
        check_quiet("idle");

        // T1: 16 words from address 0 at full rate
        drain("t1", 10'd0, 10'd1, 16, 0, 1'b0, 0, 1'b1);

        // T2: wrap past the top of the SRAM
        drain("t2", 10'd1020, 10'd1, 8, 0, 1'b0, 0, 1'b1);

        // T3: random backpressure (~30% of cycles not ready)
        drain("t3", 10'd0, 10'd1, 16, 30, 1'b0, 0, 1'b0);

        // T4: zero-length command
        i_start = 1'b1;
        i_base  = 10'd5;
        i_len   = '0;
        @(negedge clk);
        i_start = 1'b0;
        check("t4_done",  64'(done),      64'd1);
        check("t4_rd",    64'(sram_rd),   64'd0);
        check("t4_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("t4_done_after", 64'(done),      64'd0);
        check("t4_rd_after",   64'(sram_rd),   64'd0);
        check("t4_valid_after",64'(out_valid), 64'd0);

        // T4b: a second start during RUN is ignored
        drain("t4b", 10'd10, 10'd1, 4, 0, 1'b1, 0, 1'b1);

        // T5: reset after 5 accepted words, then a clean new command
        drain("t5a", 10'd200, 10'd1, 16, 0, 1'b0, 5, 1'b0);
        drain("t5b", 10'd40, 10'd1, 4, 0, 1'b0, 0, 1'b1);

        // T6: strided addressing (step 1 when the stride feature is absent)
        drain("t6", 10'd0, T6_STEP, 4, 0, 1'b0, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_gbuff_drain
